// File: rtl/ws_cart_pkg.sv
// ws_cart_pkg: cartridge unlock constants and the unlock host FSM state enum
package ws_cart_pkg;
  localparam logic [7:0] UNLOCK_ADDR_ACK = 8'h5A;
  localparam logic [7:0] UNLOCK_ADDR_NAK = 8'hA5;
  localparam logic [7:0] ADDR_IDLE = 8'hFF;
  localparam logic [15:0] UNLOCK_PAYLOAD = 16'h28A0;
  localparam int UNLOCK_FRAME_BITS = 18;
  typedef enum logic [2:0] {
    ST_IDLE, ST_SEND_ACK, ST_SEND_NAK, ST_WAIT_START, ST_SHIFT, ST_CHECK, ST_FAIL, ST_DONE
  } unlock_state_e;
endpackage

// File: rtl/ws_unlock_host_if.sv
// ws_unlock_host_if: console-facing request/status and cartridge bus signals of the unlock host
interface ws_unlock_host_if;
  logic START;
  logic SI;
  logic [7:0] ADDR;
  logic CEn;
  logic BUSY;
  logic DONE;
  logic OK;
  logic UNLOCKED;
  logic [15:0] RX_WORD;
  modport master (input START, SI, output ADDR, CEn, BUSY, DONE, OK, UNLOCKED, RX_WORD);
  modport slave (output START, SI, input ADDR, CEn, BUSY, DONE, OK, UNLOCKED, RX_WORD);
endinterface

// File: rtl/ws_unlock_deser.sv
// ws_unlock_deser: LSB-first payload shift register with saturating bit counter and stop-bit capture
module ws_unlock_deser
  import ws_cart_pkg::*;
(
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        shift_en,
  input  logic        clear,
  input  logic        si,
  output logic        full,
  output logic [15:0] word,
  output logic        stop
);
  // start bit is consumed by the FSM, so the stop bit lands at count 16
  localparam logic [4:0] LAST = 5'(UNLOCK_FRAME_BITS - 2);
  logic [4:0] cnt;
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      cnt <= '0;
      word <= '0;
      stop <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
    end else if (shift_en) begin
      if (cnt < LAST) word <= {si, word[15:1]};
      else if (cnt == LAST) stop <= si;
      if (cnt != 5'd31) cnt <= cnt + 5'd1;
    end
  assign full = cnt == LAST;
endmodule

// File: rtl/ws_unlock_host.sv
// ws_unlock_host: cartridge mapper unlock initiator; WS_UNLOCK_RETRY_EN enables retries after timeout
module ws_unlock_host
  import ws_cart_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int RETRIES = 2
) (
  input logic CLK,
  input logic RSTn,
  ws_unlock_host_if.master bus
);
  unlock_state_e state, nxt;
  logic [7:0] addr_q;
  logic [15:0] tcnt;
  logic ok_q, unl_q, done_q, full, stop;
  logic [15:0] word;
`ifdef WS_UNLOCK_RETRY_EN
  logic [7:0] att;
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) att <= '0;
    else att <= (state == ST_IDLE) ? 8'd0 : (state == ST_FAIL) ? att + 8'd1 : att;
`else
  logic [31:0] unused_retries;
  assign unused_retries = RETRIES;
`endif
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) state <= ST_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:       if (bus.START && !unl_q && !done_q) nxt = ST_SEND_ACK;
      ST_SEND_ACK:   nxt = ST_SEND_NAK;
      ST_SEND_NAK:   nxt = ST_WAIT_START;
      ST_WAIT_START: nxt = !bus.SI ? ST_SHIFT : (tcnt == 16'(TIMEOUT - 2)) ? ST_FAIL : ST_WAIT_START;
      ST_SHIFT:      if (full) nxt = ST_CHECK;
      ST_CHECK:      nxt = ST_DONE;
`ifdef WS_UNLOCK_RETRY_EN
      ST_FAIL:       nxt = (att < 8'(RETRIES)) ? ST_SEND_ACK : ST_DONE;
`else
      ST_FAIL:       nxt = ST_DONE;
`endif
      ST_DONE:       nxt = ST_IDLE;
      default:       nxt = ST_IDLE;
    endcase
  end
  // ADDR is registered from the next state so the unlock bytes line up with SEND_ACK/SEND_NAK
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      addr_q <= ADDR_IDLE;
      tcnt <= '0;
      ok_q <= 1'b0;
      unl_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      addr_q <= (nxt == ST_SEND_ACK) ? UNLOCK_ADDR_ACK : (nxt == ST_SEND_NAK) ? UNLOCK_ADDR_NAK : ADDR_IDLE;
      tcnt <= (state == ST_WAIT_START) ? tcnt + 16'd1 : 16'd0;
      ok_q <= (state == ST_CHECK) ? (word == UNLOCK_PAYLOAD && !stop) :
              (nxt == ST_SEND_ACK || state == ST_FAIL) ? 1'b0 : ok_q;
      unl_q <= unl_q | (state == ST_DONE && ok_q);
      done_q <= state == ST_DONE;
    end
  ws_unlock_deser u_deser (
    .CLK(CLK),
    .RSTn(RSTn),
    .shift_en(state == ST_SHIFT),
    .clear(state == ST_WAIT_START),
    .si(bus.SI),
    .full(full),
    .word(word),
    .stop(stop)
  );
  assign bus.ADDR = addr_q;
  assign bus.CEn = 1'b1;
  assign bus.BUSY = state != ST_IDLE;
  assign bus.DONE = done_q;
  assign bus.OK = ok_q;
  assign bus.UNLOCKED = unl_q;
  assign bus.RX_WORD = word;
endmodule

// File: tb/tb_ws_unlock_host.sv
// tb_ws_unlock_host: table-driven check of ws_unlock_host against a behavioural cartridge mapper
module tb_ws_unlock_host;
  import ws_cart_pkg::*;
  localparam int T = 64;
  localparam int R = 2;
`ifdef WS_UNLOCK_RETRY_EN
  localparam int NA = R + 1;
`else
  localparam int NA = 1;
`endif
  localparam int TO_LAT = (NA - 1) * (T + 2) + T + 3;
  logic CLK = 1'b0;
  logic RSTn = 1'b1;
  always #5 CLK = ~CLK;
  ws_unlock_host_if bus();
  ws_unlock_host #(.TIMEOUT(T), .RETRIES(R)) dut (.CLK(CLK), .RSTn(RSTn), .bus(bus));
  // mapper: loads its reply frame when it sees the NAK address, shifts it out LSB first
  logic resp = 1'b0;
  logic [17:0] frame_cfg = '1;
  logic [17:0] sh = '1;
  always @(posedge CLK)
    if (resp && bus.ADDR == UNLOCK_ADDR_NAK) sh <= frame_cfg;
    else sh <= {1'b1, sh[17:1]};
  assign bus.SI = sh[0];
  int ack_tot = 0, nak_tot = 0, bad_tot = 0, done_tot = 0;
  always @(negedge CLK) begin
    if (bus.ADDR == UNLOCK_ADDR_ACK) ack_tot++;
    else if (bus.ADDR == UNLOCK_ADDR_NAK) nak_tot++;
    else if (bus.ADDR != ADDR_IDLE) bad_tot++;
    if (bus.DONE) done_tot++;
  end
  int pass_n = 0, tot_n = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask
  task automatic do_reset;
    @(negedge CLK) RSTn = 1'b0;
    @(negedge CLK) RSTn = 1'b1;
  endtask
  task automatic set_frame(input logic r, input logic [15:0] pay, input logic stp);
    resp = r;
    frame_cfg = {stp, pay, 1'b0};
  endtask
  task automatic run(input int poke, output int lat);
    @(negedge CLK) bus.START = 1'b1;
    @(posedge CLK);
    #1 bus.START = 1'b0;
    chk("addr_after_e0", bus.ADDR, UNLOCK_ADDR_ACK);
    @(posedge CLK);
    #1 chk("addr_after_e1", bus.ADDR, UNLOCK_ADDR_NAK);
    lat = 1;
    while (lat < 600 && !bus.DONE) begin
      @(posedge CLK);
      #1 lat++;
      bus.START = (lat == poke);
    end
    if (bus.START) begin
      @(posedge CLK);
      #1 bus.START = 1'b0;
    end
  endtask
  typedef struct {
    string nm;
    logic resp;
    logic [15:0] pay;
    logic stp;
    logic exp_ok;
    int exp_lat;
    logic [15:0] exp_word;
    logic exp_unl;
  } vec_t;
  vec_t v[5];
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal;
  end
  initial begin
    int lat, a0, n0, d0;
    v[0] = '{"good", 1'b1, 16'h28A0, 1'b0, 1'b1, 22, 16'h28A0, 1'b1};
    v[1] = '{"bad_lsb", 1'b1, 16'h28A1, 1'b0, 1'b0, 22, 16'h28A1, 1'b0};
    v[2] = '{"bad_stop", 1'b1, 16'h28A0, 1'b1, 1'b0, 22, 16'h28A0, 1'b0};
    v[3] = '{"zeros", 1'b1, 16'h0000, 1'b0, 1'b0, 22, 16'h0000, 1'b0};
    v[4] = '{"timeout", 1'b0, 16'h28A0, 1'b0, 1'b0, TO_LAT, 16'h0000, 1'b0};
    bus.START = 1'b0;
    #2 RSTn = 1'b0;
    #1;
    chk("rst_addr", bus.ADDR, ADDR_IDLE);
    chk("rst_cen", bus.CEn, 1);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_done", bus.DONE, 0);
    chk("rst_ok", bus.OK, 0);
    chk("rst_unlocked", bus.UNLOCKED, 0);
    chk("rst_rx_word", bus.RX_WORD, 0);
    @(negedge CLK);
    @(negedge CLK) RSTn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_reset();
      set_frame(v[i].resp, v[i].pay, v[i].stp);
      repeat (2) @(negedge CLK);
      a0 = ack_tot; n0 = nak_tot; d0 = done_tot;
      run(0, lat);
      chk({v[i].nm, "_latency"}, lat, v[i].exp_lat);
      chk({v[i].nm, "_ok"}, bus.OK, v[i].exp_ok);
      chk({v[i].nm, "_rx_word"}, bus.RX_WORD, v[i].exp_word);
      chk({v[i].nm, "_unlocked"}, bus.UNLOCKED, v[i].exp_unl);
      chk({v[i].nm, "_busy_at_done"}, bus.BUSY, 0);
      @(posedge CLK);
      #1 chk({v[i].nm, "_done_pulse"}, bus.DONE, 0);
      chk({v[i].nm, "_ack_cycles"}, ack_tot - a0, v[i].resp ? 1 : NA);
      chk({v[i].nm, "_nak_cycles"}, nak_tot - n0, v[i].resp ? 1 : NA);
      chk({v[i].nm, "_done_count"}, done_tot - d0, 1);
    end
    // reset in the middle of a sequence, then a clean retry
    do_reset();
    set_frame(1'b1, UNLOCK_PAYLOAD, 1'b0);
    @(negedge CLK);
    d0 = done_tot;
    bus.START = 1'b1;
    @(posedge CLK);
    #1 bus.START = 1'b0;
    repeat (10) @(posedge CLK);
    #1 RSTn = 1'b0;
    #1;
    chk("midrst_addr", bus.ADDR, ADDR_IDLE);
    chk("midrst_busy", bus.BUSY, 0);
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    repeat (20) @(negedge CLK);
    chk("midrst_no_done", done_tot - d0, 0);
    run(0, lat);
    chk("midrst_retry_latency", lat, 22);
    chk("midrst_retry_ok", bus.OK, 1);
    chk("midrst_retry_unlocked", bus.UNLOCKED, 1);
    // START once unlocked must be ignored
    a0 = ack_tot;
    @(negedge CLK) bus.START = 1'b1;
    @(negedge CLK) bus.START = 1'b0;
    repeat (4) @(negedge CLK);
    chk("unlocked_no_ack", ack_tot - a0, 0);
    chk("unlocked_busy", bus.BUSY, 0);
    chk("unlocked_sticky", bus.UNLOCKED, 1);
    chk("unlocked_ok_held", bus.OK, 1);
    // START while busy must not restart the sequence
    do_reset();
    repeat (22) @(negedge CLK);
    a0 = ack_tot;
    run(5, lat);
    chk("busy_start_latency", lat, 22);
    chk("busy_start_ok", bus.OK, 1);
    @(negedge CLK);
    chk("busy_start_ack_cycles", ack_tot - a0, 1);
    // START in the DONE cycle must be ignored
    do_reset();
    set_frame(1'b1, 16'h28A1, 1'b0);
    repeat (22) @(negedge CLK);
    a0 = ack_tot;
    run(22, lat);
    chk("done_start_latency", lat, 22);
    repeat (3) @(negedge CLK);
    chk("done_start_ack_cycles", ack_tot - a0, 1);
    chk("done_start_busy", bus.BUSY, 0);
    chk("done_start_ok", bus.OK, 0);
    chk("addr_legal", bad_tot, 0);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
